// File: rtl/vadd_ctrl_pkg.sv
// Shared definitions for the vector add/min/max/compare issue controller:
// FSM states, element-width encodings and the mask-op select bit.
package vadd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_e;

    localparam int OPSEL_MASK_BIT = 8;

    // Elements carried by one operand beat of be_w bytes at the given width.
    function automatic int elems_per_beat(input int be_w, input logic [1:0] sew);
        return be_w >> sew;
    endfunction

endpackage

// File: rtl/vadd_issue_ctrl_if.sv
// Descriptor, operand-stream and ALU-request signals of the issue controller.
// The controller uses the slave modport; the producer/consumer side uses master.
interface vadd_issue_ctrl_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int VL_WIDTH    = 11,
    parameter int OPSEL_WIDTH = 9
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                   op_valid;
    logic                   op_ready;
    logic [VL_WIDTH-1:0]    op_vl;
    logic [1:0]             op_sew;
    logic [OPSEL_WIDTH-1:0] op_opsel;
    logic                   op_avg;
    logic [ADDR_WIDTH-1:0]  op_vd_addr;

    logic                   opd_valid;
    logic                   opd_ready;
    logic [DATA_WIDTH-1:0]  opd_vec0;
    logic [DATA_WIDTH-1:0]  opd_vec1;

    logic                   alu_valid;
    logic [DATA_WIDTH-1:0]  alu_vec0;
    logic [DATA_WIDTH-1:0]  alu_vec1;
    logic [1:0]             alu_sew;
    logic [OPSEL_WIDTH-1:0] alu_opsel;
    logic                   alu_avg;
    logic [ADDR_WIDTH-1:0]  alu_addr;
    logic [2:0]             alu_start_idx;
    logic                   alu_req_start;
    logic                   alu_req_end;
    logic [BE_W-1:0]        alu_be;

    modport master (
        output op_valid, op_vl, op_sew, op_opsel, op_avg, op_vd_addr,
        output opd_valid, opd_vec0, opd_vec1,
        input  op_ready, opd_ready,
        input  alu_valid, alu_vec0, alu_vec1, alu_sew, alu_opsel, alu_avg,
        input  alu_addr, alu_start_idx, alu_req_start, alu_req_end, alu_be
    );

    modport slave (
        input  op_valid, op_vl, op_sew, op_opsel, op_avg, op_vd_addr,
        input  opd_valid, opd_vec0, opd_vec1,
        output op_ready, opd_ready,
        output alu_valid, alu_vec0, alu_vec1, alu_sew, alu_opsel, alu_avg,
        output alu_addr, alu_start_idx, alu_req_start, alu_req_end, alu_be
    );

endinterface

// File: rtl/vadd_be_gen.sv
// Byte enables for the final beat of a non-mask op: the low (rem << sew)
// bytes are enabled, saturating at a full beat.
module vadd_be_gen #(
    parameter int BE_W  = 8,
    parameter int REM_W = 12
) (
    input  logic [REM_W-1:0] rem,
    input  logic [1:0]       sew,
    output logic [BE_W-1:0]  be
);

    localparam int NB_W = REM_W + 3;

    logic [NB_W-1:0] nbytes;

    always_comb begin
        nbytes = {3'b000, rem} << sew;
        be     = '0;
        for (int i = 0; i < BE_W; i++) begin
            be[i] = (nbytes > NB_W'(i));
        end
    end

endmodule

// File: rtl/vadd_issue_ctrl.sv
// Issue sequencer for the add/min/max/compare ALU: accepts one descriptor,
// pairs each operand beat with its metadata, then waits for the pipe to drain.
module vadd_issue_ctrl
    import vadd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int VL_WIDTH    = 11,
    parameter int OPSEL_WIDTH = 9,
    parameter int ALU_LATENCY = 6
) (
    input  logic              clk,
    input  logic              rst,
    vadd_issue_ctrl_if.slave  bus,
    output logic              busy,
    output logic              done
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int BE_LOG = $clog2(BE_W);
    localparam int CNT_W  = VL_WIDTH + 1;

    ctrl_state_e            state;
    logic [VL_WIDTH-1:0]    vl_q;
    logic [1:0]             sew_q;
    logic [OPSEL_WIDTH-1:0] opsel_q;
    logic                   avg_q;
    logic [ADDR_WIDTH-1:0]  vd_q;
    logic [CNT_W-1:0]       beats_q;
    logic [CNT_W-1:0]       beat_idx;
    logic [ALU_LATENCY-1:0] inflight;

    logic [CNT_W-1:0]       epb_m1;
    logic [CNT_W-1:0]       beats_calc;
    logic [CNT_W-1:0]       elem_off;
    logic [CNT_W-1:0]       rem;
    logic [BE_W-1:0]        last_be;
    logic [BE_W-1:0]        be_next;
    logic [ADDR_WIDTH-1:0]  addr_next;
    logic                   is_mask;
    logic                   is_last;
    logic                   fire;

    // Beat count is a rounded-up divide by a power-of-two elements-per-beat.
    always_comb begin
        epb_m1     = CNT_W'(elems_per_beat(BE_W, bus.op_sew) - 1);
        beats_calc = (CNT_W'(bus.op_vl) + epb_m1) >> (BE_LOG - int'(bus.op_sew));
    end

    always_comb begin
        is_mask  = opsel_q[OPSEL_MASK_BIT];
        is_last  = (beat_idx == beats_q - CNT_W'(1));
        elem_off = beat_idx << (BE_LOG - int'(sew_q));
        rem      = CNT_W'(vl_q) - elem_off;
        fire     = (state == ST_ISSUE) && bus.opd_valid && bus.opd_ready;
        // Mask ops write one bit per element, so eight beats share one byte.
        if (is_mask) begin
            addr_next = vd_q + ADDR_WIDTH'(beat_idx >> 3);
            be_next   = '1;
        end else begin
            addr_next = vd_q + (ADDR_WIDTH'(beat_idx) << BE_LOG);
            be_next   = is_last ? last_be : '1;
        end
    end

    vadd_be_gen #(
        .BE_W  (BE_W),
        .REM_W (CNT_W)
    ) u_be_gen (
        .rem (rem),
        .sew (sew_q),
        .be  (last_be)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            vl_q              <= '0;
            sew_q             <= '0;
            opsel_q           <= '0;
            avg_q             <= 1'b0;
            vd_q              <= '0;
            beats_q           <= '0;
            beat_idx          <= '0;
            inflight          <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            bus.op_ready      <= 1'b0;
            bus.opd_ready     <= 1'b0;
            bus.alu_valid     <= 1'b0;
            bus.alu_vec0      <= '0;
            bus.alu_vec1      <= '0;
            bus.alu_sew       <= '0;
            bus.alu_opsel     <= '0;
            bus.alu_avg       <= 1'b0;
            bus.alu_addr      <= '0;
            bus.alu_start_idx <= '0;
            bus.alu_req_start <= 1'b0;
            bus.alu_req_end   <= 1'b0;
            bus.alu_be        <= '0;
        end else begin
            inflight          <= (inflight << 1) | ALU_LATENCY'(bus.alu_valid);
            done              <= 1'b0;
            bus.alu_valid     <= 1'b0;
            bus.alu_vec0      <= '0;
            bus.alu_vec1      <= '0;
            bus.alu_sew       <= '0;
            bus.alu_opsel     <= '0;
            bus.alu_avg       <= 1'b0;
            bus.alu_addr      <= '0;
            bus.alu_start_idx <= '0;
            bus.alu_req_start <= 1'b0;
            bus.alu_req_end   <= 1'b0;
            bus.alu_be        <= '0;

            case (state)
                ST_IDLE: begin
                    bus.op_ready <= 1'b1;
                    if (bus.op_valid && bus.op_ready) begin
                        vl_q         <= bus.op_vl;
                        sew_q        <= bus.op_sew;
                        opsel_q      <= bus.op_opsel;
                        avg_q        <= bus.op_avg;
                        vd_q         <= bus.op_vd_addr;
                        beats_q      <= beats_calc;
                        beat_idx     <= '0;
                        bus.op_ready <= 1'b0;
                        if (bus.op_vl == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            busy          <= 1'b1;
                            bus.opd_ready <= 1'b1;
                            state         <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (fire) begin
                        bus.alu_valid     <= 1'b1;
                        bus.alu_vec0      <= bus.opd_vec0;
                        bus.alu_vec1      <= bus.opd_vec1;
                        bus.alu_sew       <= sew_q;
                        bus.alu_opsel     <= opsel_q;
                        bus.alu_avg       <= avg_q;
                        bus.alu_addr      <= addr_next;
                        bus.alu_start_idx <= is_mask ? beat_idx[2:0] : 3'd0;
                        bus.alu_req_start <= (beat_idx == '0);
                        bus.alu_req_end   <= is_last;
                        bus.alu_be        <= be_next;
                        beat_idx          <= beat_idx + CNT_W'(1);
                        if (is_last) begin
                            bus.opd_ready <= 1'b0;
                            state         <= ST_DRAIN;
                        end
                    end
                end

                // The beat issued on the ISSUE->DRAIN edge is still on alu_valid.
                ST_DRAIN: begin
                    if (inflight == '0 && !bus.alu_valid) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    bus.op_ready <= 1'b1;
                    state        <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vadd_issue_ctrl.sv
// Directed self-checking bench for vadd_issue_ctrl with hand-computed beats.
module tb_vadd_issue_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic done;
    int   testsRun  = 0;
    int   testsFail = 0;
    int   doneCount;

    always #5 clk = ~clk;

    vadd_issue_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .VL_WIDTH(11), .OPSEL_WIDTH(9)) bus ();

    vadd_issue_ctrl #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .VL_WIDTH(11), .OPSEL_WIDTH(9), .ALU_LATENCY(6)
    ) dut (
        .clk  (clk),
        .rst  (rst_n),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkBeat(input string tag, input logic v, input logic [31:0] addr,
                             input logic [7:0] be, input logic [2:0] sidx,
                             input logic rs, input logic re);
        checkOutput({tag, "_valid"}, 64'(bus.alu_valid), 64'(v));
        checkOutput({tag, "_addr"}, 64'(bus.alu_addr), 64'(addr));
        checkOutput({tag, "_be"}, 64'(bus.alu_be), 64'(be));
        checkOutput({tag, "_sidx"}, 64'(bus.alu_start_idx), 64'(sidx));
        checkOutput({tag, "_rstart"}, 64'(bus.alu_req_start), 64'(rs));
        checkOutput({tag, "_rend"}, 64'(bus.alu_req_end), 64'(re));
    endtask

    // Presents a descriptor and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input string tag, input logic [10:0] vl, input logic [1:0] sew,
                                 input logic [8:0] opsel, input logic avg, input logic [31:0] vd);
        int n = 0;
        bus.op_valid   = 1'b1;
        bus.op_vl      = vl;
        bus.op_sew     = sew;
        bus.op_opsel   = opsel;
        bus.op_avg     = avg;
        bus.op_vd_addr = vd;
        while (bus.op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_accept_wait"}, 64'(n < 20), 64'd1);
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int expCycles);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done_lat"}, 64'(n), 64'(expCycles));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
        checkOutput({tag, "_ready_back"}, 64'(bus.op_ready), 64'd1);
        checkOutput({tag, "_busy_clr"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_vl     = '0;
        bus.op_sew    = '0;
        bus.op_opsel  = '0;
        bus.op_avg    = 1'b0;
        bus.op_vd_addr = '0;
        bus.opd_valid = 1'b0;
        bus.opd_vec0  = '0;
        bus.opd_vec1  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_op_ready", 64'(bus.op_ready), 64'd0);
        checkOutput("rst_opd_ready", 64'(bus.opd_ready), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkBeat("rst", 1'b0, 32'h0, 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 64'(bus.op_ready), 64'd1);

        // sew=8b, vl=16, plain add: two full beats
        applyStimulus("t1", 11'd16, 2'd0, 9'h001, 1'b0, 32'h100);
        bus.opd_valid = 1'b1;
        bus.opd_vec0  = 64'hA0;
        bus.opd_vec1  = 64'hB0;
        @(negedge clk);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        checkOutput("t1_opd_ready", 64'(bus.opd_ready), 64'd1);
        @(posedge clk);
        #1 bus.opd_vec0 = 64'hA1;
        @(negedge clk);
        checkBeat("t1_b0", 1'b1, 32'h100, 8'hFF, 3'd0, 1'b1, 1'b0);
        checkOutput("t1_b0_vec0", bus.alu_vec0, 64'hA0);
        checkOutput("t1_b0_vec1", bus.alu_vec1, 64'hB0);
        checkOutput("t1_b0_opsel", 64'(bus.alu_opsel), 64'h001);
        @(posedge clk);
        #1 bus.opd_valid = 1'b0;
        @(negedge clk);
        checkBeat("t1_b1", 1'b1, 32'h108, 8'hFF, 3'd0, 1'b0, 1'b1);
        checkOutput("t1_b1_vec0", bus.alu_vec0, 64'hA1);
        checkOutput("t1_opd_ready_off", 64'(bus.opd_ready), 64'd0);
        checkOutput("t1_no_accept", 64'(bus.op_ready), 64'd0);
        waitDone("t1", 8);

        // sew=32b, vl=3, averaging: partial last beat
        applyStimulus("t2", 11'd3, 2'd2, 9'h005, 1'b1, 32'h200);
        bus.opd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkBeat("t2_b0", 1'b1, 32'h200, 8'hFF, 3'd0, 1'b1, 1'b0);
        checkOutput("t2_b0_avg", 64'(bus.alu_avg), 64'd1);
        checkOutput("t2_b0_sew", 64'(bus.alu_sew), 64'd2);
        @(posedge clk);
        #1 bus.opd_valid = 1'b0;
        @(negedge clk);
        checkBeat("t2_b1", 1'b1, 32'h208, 8'h0F, 3'd0, 1'b0, 1'b1);
        checkOutput("t2_b1_avg", 64'(bus.alu_avg), 64'd1);
        waitDone("t2", 8);
        doneCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) doneCount++;
        end
        checkOutput("t2_single_done", 64'(doneCount), 64'd0);

        // Mask-producing compare: sew=8b, vl=80, ten beats
        applyStimulus("t3", 11'd80, 2'd0, 9'h103, 1'b0, 32'h40);
        bus.opd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (i == 9) #1 bus.opd_valid = 1'b0;
            @(negedge clk);
            checkBeat($sformatf("t3_b%0d", i), 1'b1, 32'h40 + 32'(i / 8), 8'hFF,
                      3'(i % 8), (i == 0), (i == 9));
        end
        waitDone("t3", 8);

        // vl=0: no beats, immediate done
        applyStimulus("t4", 11'd0, 2'd1, 9'h002, 1'b0, 32'h80);
        @(negedge clk);
        checkOutput("t4_done", 64'(done), 64'd1);
        checkOutput("t4_busy", 64'(busy), 64'd0);
        checkOutput("t4_alu_valid", 64'(bus.alu_valid), 64'd0);
        checkOutput("t4_opd_ready", 64'(bus.opd_ready), 64'd0);
        @(negedge clk);
        checkOutput("t4_done_clr", 64'(done), 64'd0);
        checkOutput("t4_ready_back", 64'(bus.op_ready), 64'd1);

        // Bubbled operand stream: sew=8b, vl=32, opd_valid 1,0,1,0...
        applyStimulus("t5", 11'd32, 2'd0, 9'h004, 1'b0, 32'h300);
        bus.opd_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1 bus.opd_valid = ((k + 1) % 2 == 0);
            @(negedge clk);
            if (k % 2 == 0)
                checkBeat($sformatf("t5_c%0d", k), 1'b1, 32'h300 + 32'(8 * (k / 2)), 8'hFF,
                          3'd0, (k == 0), (k == 6));
            else
                checkBeat($sformatf("t5_c%0d", k), 1'b0, 32'h0, 8'h00, 3'd0, 1'b0, 1'b0);
        end
        waitDone("t5", 8);

        // Reset pulse during DRAIN aborts without a done pulse
        applyStimulus("t6", 11'd8, 2'd0, 9'h001, 1'b0, 32'h500);
        bus.opd_valid = 1'b1;
        @(posedge clk);
        #1 bus.opd_valid = 1'b0;
        @(negedge clk);
        checkBeat("t6_b0", 1'b1, 32'h500, 8'hFF, 3'd0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("t6_in_drain", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_busy", 64'(busy), 64'd0);
        checkOutput("t6_rst_ready", 64'(bus.op_ready), 64'd0);
        checkOutput("t6_rst_done", 64'(done), 64'd0);
        checkBeat("t6_rst", 1'b0, 32'h0, 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_ready_after", 64'(bus.op_ready), 64'd1);
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) doneCount++;
        end
        checkOutput("t6_no_done", 64'(doneCount), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/vadd_issue_ctrl.md
Name: vadd_issue_ctrl

Overview:
- Sequencer for the add/min/max/compare ALU pipeline.
- Accepts one vector-op descriptor at a time over a valid/ready handshake.
- Pairs each operand beat from the operand stream with its metadata and drives the ALU request port: valid, sew, opSel, addr, start_idx, req_start, req_end, be, avg.
- Tracks in-flight beats and pulses done once the last ALU result has left the pipeline.

Parameters:
- DATA_WIDTH, 64, operand beat width (bits); BE_W = DATA_WIDTH/8.
- ADDR_WIDTH, 32, destination address width.
- VL_WIDTH, 11, element-count width.
- OPSEL_WIDTH, 9, ALU op-select width.
- ALU_LATENCY, 6, cycles from ALU in_valid to ALU out_valid.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- op_valid  in  1  descriptor valid
- op_ready  out  1  descriptor accepted when op_valid & op_ready
- op_vl  in  VL_WIDTH  element count
- op_sew  in  2  element width (0=8b … 3=64b)
- op_opsel  in  OPSEL_WIDTH  ALU op select; bit 8 = mask-producing compare
- op_avg  in  1  averaging (fixed-point) op
- op_vd_addr  in  ADDR_WIDTH  destination base address
- opd_valid  in  1  operand beat valid
- opd_ready  out  1  operand beat consumed
- opd_vec0, opd_vec1  in  DATA_WIDTH  operand beats
- alu_valid  out  1  ALU request valid
- alu_vec0, alu_vec1  out  DATA_WIDTH  registered operands
- alu_sew  out  2; alu_opsel  out  OPSEL_WIDTH; alu_avg  out  1
- alu_addr  out  ADDR_WIDTH  beat destination address
- alu_start_idx  out  3  mask bit offset
- alu_req_start  out  1  first beat of op
- alu_req_end  out  1  last beat of op
- alu_be  out  BE_W  byte enables
- busy  out  1  op accepted and not yet done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, async): FSM=IDLE, counters cleared, in-flight shift register cleared. Outputs: op_ready=0, opd_ready=0, busy=0, done=0, all alu_* =0.
- First cycle after reset release: op_ready=1.
- FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - op_ready=1.
  - On accept, latch the descriptor and compute beats = ceil(vl / (BE_W>>sew)).
  - vl=0: go straight to DONE; no beats issued.
- ISSUE:
  - opd_ready=1.
  - Each opd_valid cycle registers one ALU request (1-cycle latency, opd to alu_*).
  - Cycles without opd_valid drive alu_valid=0 and all other alu_* =0.
  - beat_idx counts 0..beats-1.
  - After the last beat is consumed: opd_ready=0 in the next cycle; go to DRAIN.
- Per-beat fields:
  - alu_req_start = (beat_idx==0).
  - alu_req_end = (beat_idx==beats-1).
  - Non-mask ops: alu_addr = vd_addr + beat_idx*BE_W; alu_start_idx=0.
  - Non-mask alu_be: all ones, except on the last beat: low (rem<<sew) bits set, rem = vl - beat_idx*(BE_W>>sew).
  - Mask ops (opsel[8]=1): alu_start_idx = beat_idx[2:0]; alu_addr = vd_addr + (beat_idx>>3); alu_be = all ones (the ALU generates mask byte enables).
- In-flight tracking:
  - ALU_LATENCY-deep shift register shifts in alu_valid every cycle.
  - DRAIN exits to DONE when the register is all zero.
- DONE: done=1 for exactly one cycle, busy=0; next cycle IDLE with op_ready=1.
- busy=1 in ISSUE and DRAIN.
- A new descriptor is never accepted while busy; an op_valid held during busy waits.
- Reset asserted mid-ISSUE/DRAIN: op aborted, no done pulse; downstream results already in flight are the consumer's responsibility.
- Arithmetic:
  - beats computed with VL_WIDTH+1 bits.
  - Address adds wrap modulo 2^ADDR_WIDTH.
  - vl=max with sew=3 must not overflow beat_idx.

Decomposition:
- Shared package vadd_ctrl_pkg: FSM state encoding (IDLE, ISSUE, DRAIN, DONE), SEW encodings, the OPSEL mask-bit index (8), and the function elems_per_beat(sew) = BE_W>>sew.
- One sub-module: vadd_be_gen (combinational last-beat byte-enable from rem and sew).

Test Plan:
- sew=0, vl=16, add, vd=0x100, opd every cycle -> 2 beats, addr 0x100/0x108, be 0xFF/0xFF, req_start on beat 0, req_end on beat 1, done 1+6+1 cycles after last beat.
- sew=2, vl=3, avg=1 -> 2 beats, second be=0x0F, alu_avg=1 on both beats, single done pulse.
- sew=0, vl=80, opsel[8]=1, vd=0x40 -> 10 beats, start_idx 0..7,0,1, addr 0x40 for beats 0-7 and 0x41 for beats 8-9, req_end on beat 9.
- vl=0 -> no alu_valid, done asserted 1 cycle after accept, op_ready back the following cycle.
- opd_valid toggling 1,0,1,0 with vl=32, sew=0 -> 4 beats with bubbles (alu_valid=0 in gaps), done only after the in-flight register empties.
- rst low for 1 cycle in the middle of DRAIN -> all outputs 0 immediately, no done, op_ready=1 after release.
